// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/exception addresses, fetch FSM states and
// the IF->ID slot record.
package cpu_pkg;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        ERR
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } if_slot_t;

endpackage

// File: rtl/if_slot_buf.sv
// One-entry IF output slot with valid/ready handshake and flush, plus a
// one-entry side buffer for a fetch that returned while the slot was full.
module if_slot_buf
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush_i,
    input  logic     load_i,
    input  if_slot_t load_slot_i,
    input  logic     stash_i,
    input  if_slot_t stash_slot_i,
    input  logic     promote_i,
    input  logic     ready_i,
    output if_slot_t slot_o
);

    if_slot_t slot_q, slot_d;
    if_slot_t hold_q, hold_d;

    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        slot_d = slot_q;
        hold_d = hold_q;

        if (slot_q.valid && ready_i) begin
            slot_d.valid = 1'b0;
        end
        if (flush_i) begin
            slot_d.valid = 1'b0;
        end
        // A load after a flush is how an address-error entry replaces flushed contents.
        if (load_i) begin
            slot_d = load_slot_i;
        end else if (promote_i && hold_q.valid) begin
            slot_d = hold_q;
        end

        if (stash_i) begin
            hold_d = stash_slot_i;
        end
        if (flush_i || promote_i) begin
            hold_d.valid = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            hold_q <= '0;
        end else begin
            slot_q <= slot_d;
            hold_q <= hold_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues one outstanding request
// at a time on the instruction bus and applies branch/exception redirects.
module fetch_ctrl #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_redirect,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_redirect,
    input  logic [ADDR_W-1:0] exc_target,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [31:0]       inst_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr,
    output logic              if_adel
);
    import cpu_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic              redir;
    logic [ADDR_W-1:0] tgt;
    logic              slot_free;
    logic              jump;
    logic [ADDR_W-1:0] jump_pc;
    logic              flush, load, stash, promote;
    if_slot_t          load_slot, fetched, slot;

    always_comb begin
        redir     = exc_redirect | br_redirect;
        tgt       = exc_redirect ? exc_target : br_target;
        slot_free = !slot.valid || if_ready;
        fetched   = '{valid: 1'b1, pc: pc_q, instr: inst_rdata, adel: 1'b0};

        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        jump      = 1'b0;
        jump_pc   = pc_q;
        flush     = 1'b0;
        load      = 1'b0;
        load_slot = fetched;
        stash     = 1'b0;
        promote   = 1'b0;

        case (state_q)
            REQ: begin
                if (inst_addr_ok) begin
                    state_d = WAIT;
                    if (redir) begin
                        pend_d    = 1'b1;
                        pend_pc_d = tgt;
                        flush     = 1'b1;
                    end
                end else if (redir) begin
                    jump    = 1'b1;
                    jump_pc = tgt;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (redir) begin
                        jump    = 1'b1;
                        jump_pc = tgt;
                    end else if (pend_q) begin
                        jump    = 1'b1;
                        jump_pc = pend_pc_q;
                    end else if (slot_free) begin
                        load    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = REQ;
                    end else begin
                        stash   = 1'b1;
                        state_d = HOLD;
                    end
                end else if (redir) begin
                    pend_d    = 1'b1;
                    pend_pc_d = tgt;
                    flush     = 1'b1;
                end
            end
            HOLD: begin
                if (redir) begin
                    jump    = 1'b1;
                    jump_pc = tgt;
                end else if (if_ready) begin
                    promote = 1'b1;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = REQ;
                end
            end
            ERR: begin
                if (redir) begin
                    jump    = 1'b1;
                    jump_pc = tgt;
                end
            end
            default: state_d = REQ;
        endcase

        // Every non-sequential PC change funnels through here; a misaligned
        // target never reaches the bus and is reported through the slot.
        if (jump) begin
            flush  = 1'b1;
            pend_d = 1'b0;
            pc_d   = jump_pc;
            if (jump_pc[1:0] != 2'b00) begin
                state_d   = ERR;
                load      = 1'b1;
                load_slot = '{valid: 1'b1, pc: jump_pc, instr: 32'h0, adel: 1'b1};
            end else begin
                state_d = REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    if_slot_buf u_slot (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .load_i       (load),
        .load_slot_i  (load_slot),
        .stash_i      (stash),
        .stash_slot_i (fetched),
        .promote_i    (promote),
        .ready_i      (if_ready),
        .slot_o       (slot)
    );

    assign inst_req  = (state_q == REQ) && !rst;
    assign inst_addr = pc_q;
    assign if_valid  = slot.valid;
    assign if_pc     = slot.pc;
    assign if_instr  = slot.instr;
    assign if_adel   = slot.valid & slot.adel;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change and outputs are sampled on the
// falling edge; expected values are hand-derived constants.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_redirect, exc_redirect;
    logic [31:0] br_target, exc_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid, if_ready, if_adel;
    logic [31:0] if_pc, if_instr;

    int n_pass  = 0;
    int n_total = 0;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .br_redirect  (br_redirect),
        .br_target    (br_target),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_adel      (if_adel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        br_redirect = 1'b0; br_target = '0;
        exc_redirect = 1'b0; exc_target = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        if_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_req",   inst_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_pc",    if_pc,    0);
        check("rst_instr", if_instr, 0);
        check("rst_adel",  if_adel,  0);
        rst = 1'b0;
        tick();

        // 1: back-to-back fetch, one instruction per two cycles
        check("t1_req0",  inst_req,  1);
        check("t1_addr0", inst_addr, 32'hBFC0_0000);
        inst_addr_ok = 1'b1;
        tick();
        check("t1_wait_req", inst_req, 0);
        check("t1_wait_vld", if_valid, 0);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_0000;
        tick();
        check("t1_vld0",   if_valid,  1);
        check("t1_pc0",    if_pc,     32'hBFC0_0000);
        check("t1_instr0", if_instr,  32'h1111_0000);
        check("t1_addr1",  inst_addr, 32'hBFC0_0004);
        inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
        tick();
        check("t1_consumed", if_valid, 0);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_0004;
        tick();
        check("t1_vld1",  if_valid,  1);
        check("t1_pc1",   if_pc,     32'hBFC0_0004);
        check("t1_addr2", inst_addr, 32'hBFC0_0008);

        // 2: data returns while ID stalls -> buffered, released on if_ready
        inst_data_ok = 1'b0; inst_addr_ok = 1'b1; if_ready = 1'b0;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2222_0008;
        tick();
        check("t2_hold_req",   inst_req, 0);
        check("t2_hold_instr", if_instr, 32'h1111_0004);
        inst_data_ok = 1'b0;
        tick();
        tick();
        check("t2_hold_req2", inst_req, 0);
        check("t2_hold_vld",  if_valid, 1);
        if_ready = 1'b1;
        tick();
        check("t2_vld",   if_valid,  1);
        check("t2_pc",    if_pc,     32'hBFC0_0008);
        check("t2_instr", if_instr,  32'h2222_0008);
        check("t2_req",   inst_req,  1);
        check("t2_addr",  inst_addr, 32'hBFC0_000C);

        // 3: branch during WAIT drops the returning data
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; br_redirect = 1'b1; br_target = 32'h8000_1000;
        tick();
        br_redirect = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3333_3333;
        tick();
        check("t3_dropped", if_valid,  0);
        check("t3_req",     inst_req,  1);
        check("t3_addr",    inst_addr, 32'h8000_1000);
        inst_data_ok = 1'b0;

        // 4: exception beats branch in the same cycle and flushes a valid slot
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h4444_4444;
        tick();
        inst_data_ok = 1'b0;
        check("t4_vld", if_valid, 1);
        check("t4_pc",  if_pc,    32'h8000_1000);
        exc_redirect = 1'b1; exc_target = 32'hBFC0_0380;
        br_redirect  = 1'b1; br_target  = 32'h8000_2000;
        tick();
        exc_redirect = 1'b0; br_redirect = 1'b0;
        check("t4_flush", if_valid,  0);
        check("t4_req",   inst_req,  1);
        check("t4_addr",  inst_addr, 32'hBFC0_0380);

        // 5: misaligned target -> address-error slot, no request
        if_ready = 1'b0; br_redirect = 1'b1; br_target = 32'h8000_0002;
        tick();
        br_redirect = 1'b0;
        check("t5_req",   inst_req, 0);
        check("t5_vld",   if_valid, 1);
        check("t5_adel",  if_adel,  1);
        check("t5_pc",    if_pc,    32'h8000_0002);
        check("t5_instr", if_instr, 0);
        tick();
        check("t5_req_stay",  inst_req, 0);
        check("t5_adel_stay", if_adel,  1);
        exc_redirect = 1'b1; exc_target = 32'hBFC0_0380;
        tick();
        exc_redirect = 1'b0;
        check("t5_resume_req",  inst_req,  1);
        check("t5_resume_addr", inst_addr, 32'hBFC0_0380);
        check("t5_resume_vld",  if_valid,  0);
        check("t5_resume_adel", if_adel,   0);

        // 6: pc+4 wraps, then reset mid-transaction ignores the late data
        if_ready = 1'b1; br_redirect = 1'b1; br_target = 32'hFFFF_FFFC;
        tick();
        br_redirect = 1'b0;
        check("t6_addr_top", inst_addr, 32'hFFFF_FFFC);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h6666_6666;
        tick();
        inst_data_ok = 1'b0;
        check("t6_wrap_addr", inst_addr, 32'h0000_0000);
        check("t6_wrap_pc",   if_pc,     32'hFFFF_FFFC);
        check("t6_wrap_vld",  if_valid,  1);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; rst = 1'b1;
        tick();
        check("t6_rst_req", inst_req, 0);
        check("t6_rst_vld", if_valid, 0);
        rst = 1'b0;
        tick();
        check("t6_post_req",  inst_req,  1);
        check("t6_post_addr", inst_addr, 32'hBFC0_0000);
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        tick();
        inst_data_ok = 1'b0;
        check("t6_late_req",  inst_req,  1);
        check("t6_late_addr", inst_addr, 32'hBFC0_0000);
        check("t6_late_vld",  if_valid,  0);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h7777_7777;
        tick();
        inst_data_ok = 1'b0;
        check("t6_fresh_vld",   if_valid, 1);
        check("t6_fresh_pc",    if_pc,    32'hBFC0_0000);
        check("t6_fresh_instr", if_instr, 32'h7777_7777);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
